// File: rtl/circle_engine.sv
// Bresenham circle rasteriser: outline or filled disc, one generated pixel per clock,
// clipped to the visible screen, with a busy/done handshake around each circle.
module circle_engine #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int R_W   = 6,
    parameter int COL_W = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             fill,
    input  logic [X_W-1:0]   centre_x,
    input  logic [Y_W-1:0]   centre_y,
    input  logic [R_W-1:0]   radius,
    input  logic [COL_W-1:0] colour,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic             vga_plot,
    output logic [COL_W-1:0] vga_colour,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_SPAN, S_STEP, S_DONE} state_t;
    typedef logic signed [X_W+1:0] xc_t;
    typedef logic signed [Y_W+1:0] yc_t;
    typedef logic signed [R_W+1:0] rc_t;
    typedef logic signed [R_W+3:0] d_t;

    localparam xc_t XMAX_S = xc_t'(X_MAX);
    localparam yc_t YMAX_S = yc_t'(Y_MAX);
    localparam xc_t X_ONE  = xc_t'(1);
    localparam rc_t R_ONE  = rc_t'(1);
    localparam d_t  D_3    = d_t'(3);
    localparam d_t  D_6    = d_t'(6);
    localparam d_t  D_10   = d_t'(10);

    state_t           state_q, state_d;
    logic             fill_q, fill_d;
    xc_t              cx_q, cx_d;
    yc_t              cy_q, cy_d;
    logic [R_W-1:0]   r_q, r_d;
    logic [COL_W-1:0] colour_q, colour_d;
    rc_t              x_q, x_d, y_q, y_d;
    d_t               d_q, d_d;
    logic [2:0]       k_q, k_d;
    logic [1:0]       s_q, s_d;
    xc_t              sx_q, sx_d;

    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic             vga_plot_q, vga_plot_d;
    logic [COL_W-1:0] vga_colour_q, vga_colour_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    xc_t  px, xx, xy, span_r;
    yc_t  py, yx, yy;
    d_t   dx, dy;
    rc_t  xn, yn;
    logic gen, vis;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        d_d      = d_q;
        k_d      = k_q;
        s_d      = s_q;
        sx_d     = sx_q;
        px       = '0;
        py       = '0;
        gen      = 1'b0;
        xx       = xc_t'(x_q);
        xy       = xc_t'(y_q);
        yx       = yc_t'(x_q);
        yy       = yc_t'(y_q);
        dx       = d_t'(x_q);
        dy       = d_t'(y_q);
        xn       = x_q + R_ONE;
        yn       = y_q;
        span_r   = s_q[1] ? cx_q + xy : cx_q + xx;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fill_d   = fill;
                    cx_d     = xc_t'(centre_x);
                    cy_d     = yc_t'(centre_y);
                    r_d      = radius;
                    colour_d = colour;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                x_d     = '0;
                y_d     = rc_t'(r_q);
                d_d     = D_3 - (d_t'(r_q) <<< 1);
                k_d     = '0;
                s_d     = '0;
                sx_d    = cx_q;
                state_d = fill_q ? S_SPAN : S_PLOT;
            end
            S_PLOT: begin
                gen = 1'b1;
                case (k_q)
                    3'd0: begin px = cx_q + xx; py = cy_q + yy; end
                    3'd1: begin px = cx_q + xy; py = cy_q + yx; end
                    3'd2: begin px = cx_q - xx; py = cy_q + yy; end
                    3'd3: begin px = cx_q - xy; py = cy_q + yx; end
                    3'd4: begin px = cx_q - xx; py = cy_q - yy; end
                    3'd5: begin px = cx_q - xy; py = cy_q - yx; end
                    3'd6: begin px = cx_q + xx; py = cy_q - yy; end
                    default: begin px = cx_q + xy; py = cy_q - yx; end
                endcase
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = S_STEP;
                end
            end
            S_SPAN: begin
                gen = 1'b1;
                px  = sx_q;
                case (s_q)
                    2'd0:    py = cy_q + yy;
                    2'd1:    py = cy_q - yy;
                    2'd2:    py = cy_q + yx;
                    default: py = cy_q - yx;
                endcase
                // Spans 0/1 run over +-x, spans 2/3 over +-y; the next left edge follows.
                if (sx_q == span_r) begin
                    if (s_q == 2'd3) begin
                        state_d = S_STEP;
                    end else begin
                        s_d  = s_q + 2'd1;
                        sx_d = (s_q != 2'd0) ? cx_q - xy : cx_q - xx;
                    end
                end else begin
                    sx_d = sx_q + X_ONE;
                end
            end
            S_STEP: begin
                if (d_q[R_W+3]) begin
                    d_d = d_q + (dx <<< 2) + D_6;
                end else begin
                    d_d = d_q + ((dx - dy) <<< 2) + D_10;
                    yn  = y_q - R_ONE;
                end
                x_d = xn;
                y_d = yn;
                if (xn <= yn) begin
                    k_d     = '0;
                    s_d     = '0;
                    sx_d    = cx_q - xc_t'(xn);
                    state_d = fill_q ? S_SPAN : S_PLOT;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        vis = gen && !px[X_W+1] && (px <= XMAX_S) && !py[Y_W+1] && (py <= YMAX_S);
        vga_plot_d   = vis;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if (vis) begin
            vga_x_d      = px[X_W-1:0];
            vga_y_d      = py[Y_W-1:0];
            vga_colour_d = colour_q;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_q       <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
            colour_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            d_q          <= '0;
            k_q          <= '0;
            s_q          <= '0;
            sx_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_plot_q   <= 1'b0;
            vga_colour_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            r_q          <= r_d;
            colour_q     <= colour_d;
            x_q          <= x_d;
            y_q          <= y_d;
            d_q          <= d_d;
            k_q          <= k_d;
            s_q          <= s_d;
            sx_q         <= sx_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_plot_q   <= vga_plot_d;
            vga_colour_q <= vga_colour_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_plot   = vga_plot_q;
    assign vga_colour = vga_colour_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_circle_engine.sv
// Self-checking bench for circle_engine: directed test-plan scenarios plus random circles,
// each compared cycle by cycle against an integer model of the midpoint circle algorithm.
module tb_circle_engine;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       start    = 1'b0;
    logic       fill     = 1'b0;
    logic [7:0] centre_x = '0;
    logic [6:0] centre_y = '0;
    logic [5:0] radius   = '0;
    logic [2:0] colour   = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic       vga_plot;
    logic [2:0] vga_colour;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle output stream for one circle (STEP cycles appear as plot=0 entries).
    int q_plot[$];
    int q_x[$];
    int q_y[$];
    int got_x[$];
    int got_y[$];
    int exp_col;
    int done_j;
    int r5_done_j;

    circle_engine #(
        .X_W(8), .Y_W(7), .R_W(6), .COL_W(3), .X_MAX(159), .Y_MAX(119)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .fill(fill),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_plot(vga_plot), .vga_colour(vga_colour),
        .busy(busy), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1);
    end

    task automatic push_px(input int px, input int py);
        q_plot.push_back((px >= 0 && px <= 159 && py >= 0 && py <= 119) ? 1 : 0);
        q_x.push_back(px);
        q_y.push_back(py);
    endtask

    task automatic build_model(input int cx, input int cy, input int r, input bit f);
        int x, y, d;
        int ox[8];
        int oy[8];
        q_plot.delete();
        q_x.delete();
        q_y.delete();
        x = 0;
        y = r;
        d = 3 - 2 * r;
        do begin
            if (!f) begin
                ox = '{x, y, -x, -y, -x, -y, x, y};
                oy = '{y, x, y, x, -y, -x, -y, -x};
                for (int k = 0; k < 8; k++) push_px(cx + ox[k], cy + oy[k]);
            end else begin
                for (int i = cx - x; i <= cx + x; i++) push_px(i, cy + y);
                for (int i = cx - x; i <= cx + x; i++) push_px(i, cy - y);
                for (int i = cx - y; i <= cx + y; i++) push_px(i, cy + x);
                for (int i = cx - y; i <= cx + y; i++) push_px(i, cy - x);
            end
            q_plot.push_back(0);
            q_x.push_back(0);
            q_y.push_back(0);
            if (d < 0) begin
                d = d + 4 * x + 6;
            end else begin
                d = d + 4 * (x - y) + 10;
                y = y - 1;
            end
            x = x + 1;
        end while (x <= y);
    endtask

    task automatic accept(input int cx, input int cy, input int r, input bit f,
                          input int col, input bit hold);
        build_model(cx, cy, r, f);
        exp_col = col;
        @(negedge CLOCK_50);
        centre_x = 8'(cx);
        centre_y = 7'(cy);
        radius   = 6'(r);
        fill     = f;
        colour   = 3'(col);
        start    = 1'b1;
        @(posedge CLOCK_50);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Runs from just after the accept edge to the first IDLE cycle after done.
    task automatic check_trace(input string name, input bit pulse);
        int len, ep, ex, ey;
        len = q_plot.size();
        got_x.delete();
        got_y.delete();
        done_j = -1;
        checks++;
        if (busy !== 1'b1 || vga_plot !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: busy=%b plot=%b done=%b want busy=1 plot=0 done=0",
                     name, busy, vga_plot, done);
        end
        for (int j = 1; j <= len + 1; j++) begin
            @(posedge CLOCK_50);
            #1;
            ep = (j >= 2) ? q_plot[j-2] : 0;
            checks++;
            if (vga_plot !== ep[0]) begin
                failures++;
                $display("FAIL %s plot cycle %0d: got=%b want=%0d", name, j, vga_plot, ep);
            end
            if (vga_plot === 1'b1) begin
                got_x.push_back(int'(vga_x));
                got_y.push_back(int'(vga_y));
            end
            if (ep == 1) begin
                ex = q_x[j-2];
                ey = q_y[j-2];
                checks++;
                if (vga_x !== ex[7:0] || vga_y !== ey[6:0] || vga_colour !== exp_col[2:0]) begin
                    failures++;
                    $display("FAIL %s pixel cycle %0d: got=(%0d,%0d,c%0d) want=(%0d,%0d,c%0d)",
                             name, j, vga_x, vga_y, vga_colour, ex, ey, exp_col);
                end
            end
            checks++;
            if (busy !== (j <= len) || done !== (j == len + 1)) begin
                failures++;
                $display("FAIL %s handshake cycle %0d: got busy=%b done=%b want busy=%b done=%b",
                         name, j, busy, done, (j <= len), (j == len + 1));
            end
            if (done === 1'b1 && done_j < 0) done_j = j;
            if (pulse && j == 4) begin
                start    = 1'b1;
                centre_x = 8'($urandom_range(0, 255));
                centre_y = 7'($urandom_range(0, 127));
                radius   = 6'($urandom_range(0, 63));
            end
            if (pulse && j == 5) start = 1'b0;
        end
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vga_plot !== 1'b0) begin
            failures++;
            $display("FAIL %s after done: busy=%b done=%b plot=%b want all 0",
                     name, busy, done, vga_plot);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_plot !== 1'b0 || vga_colour !== 3'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset: got x=%0d y=%0d plot=%b col=%0d busy=%b done=%b want all 0",
                     vga_x, vga_y, vga_plot, vga_colour, busy, done);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_outline_r1();
        int ex[8];
        int ey[8];
        ex = '{80, 81, 80, 79, 80, 79, 80, 81};
        ey = '{61, 60, 61, 60, 59, 60, 59, 60};
        accept(80, 60, 1, 1'b0, 5, 1'b0);
        check_trace("outline_r1", 1'b0);
        checks++;
        if (got_x.size() != 8) begin
            failures++;
            $display("FAIL outline_r1 count: got=%0d want=8", got_x.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_x[i] != ex[i] || got_y[i] != ey[i]) begin
                    failures++;
                    $display("FAIL outline_r1 order %0d: got=(%0d,%0d) want=(%0d,%0d)",
                             i, got_x[i], got_y[i], ex[i], ey[i]);
                end
            end
        end
    endtask

    task automatic test_outline_r5();
        int bad;
        accept(80, 60, 5, 1'b0, 2, 1'b0);
        check_trace("outline_r5", 1'b0);
        r5_done_j = done_j;
        checks++;
        if (got_x.size() != 32 || done_j != 37) begin
            failures++;
            $display("FAIL outline_r5 length: got plots=%0d done_at=%0d want plots=32 done_at=37",
                     got_x.size(), done_j);
        end
        checks++;
        if (got_x.size() < 2 || got_x[1] != 85 || got_y[1] != 60) begin
            failures++;
            $display("FAIL outline_r5 second pixel: got=(%0d,%0d) want=(85,60)",
                     (got_x.size() > 1) ? got_x[1] : -1, (got_y.size() > 1) ? got_y[1] : -1);
        end
        bad = 0;
        foreach (got_x[i])
            if (got_x[i] < 75 || got_x[i] > 85 || got_y[i] < 55 || got_y[i] > 65) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL outline_r5 extent: got=%0d out-of-box pixels want=0", bad);
        end
    endtask

    task automatic test_fill();
        int bad, found, dx, dy;
        accept(10, 10, 0, 1'b1, 6, 1'b0);
        check_trace("fill_r0", 1'b0);
        bad = 0;
        foreach (got_x[i]) if (got_x[i] != 10 || got_y[i] != 10) bad++;
        checks++;
        if (got_x.size() != 4 || bad != 0) begin
            failures++;
            $display("FAIL fill_r0: got plots=%0d off-centre=%0d want plots=4 off-centre=0",
                     got_x.size(), bad);
        end
        accept(20, 20, 2, 1'b1, 1, 1'b0);
        check_trace("fill_r2", 1'b0);
        for (int ddx = -2; ddx <= 2; ddx++) begin
            for (int ddy = -2; ddy <= 2; ddy++) begin
                if (ddx * ddx + ddy * ddy <= 4) begin
                    found = 0;
                    foreach (got_x[i]) if (got_x[i] == 20 + ddx && got_y[i] == 20 + ddy) found = 1;
                    checks++;
                    if (found == 0) begin
                        failures++;
                        $display("FAIL fill_r2 coverage (%0d,%0d): got=missing want=written",
                                 20 + ddx, 20 + ddy);
                    end
                end
            end
        end
        // Integer radius: anything with dx^2+dy^2 >= 9 lies at radius 3 or beyond.
        bad = 0;
        foreach (got_x[i]) begin
            dx = got_x[i] - 20;
            dy = got_y[i] - 20;
            if (dx * dx + dy * dy >= 9) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill_r2 extent: got=%0d pixels beyond radius 2 want=0", bad);
        end
    endtask

    task automatic test_clip();
        int bad;
        accept(0, 0, 5, 1'b0, 3, 1'b0);
        check_trace("clip_origin", 1'b0);
        checks++;
        if (done_j != r5_done_j) begin
            failures++;
            $display("FAIL clip_origin cycles: got done_at=%0d want=%0d", done_j, r5_done_j);
        end
        bad = 0;
        foreach (got_x[i]) if (got_x[i] > 5 || got_y[i] > 5) bad++;
        checks++;
        if (bad != 0 || got_x.size() == 0) begin
            failures++;
            $display("FAIL clip_origin strobes: got wrapped=%0d plots=%0d want wrapped=0 plots>0",
                     bad, got_x.size());
        end
    endtask

    task automatic test_handshake();
        accept(40, 50, 7, 1'b0, 1, 1'b0);
        check_trace("start_while_busy", 1'b1);
        accept(30, 30, 3, 1'b1, 4, 1'b1);
        check_trace("held_start_first", 1'b0);
        // start is still high: the circle after DONE begins on this first IDLE edge.
        build_model(100, 70, 4, 1'b0);
        exp_col  = 6;
        centre_x = 8'd100;
        centre_y = 7'd70;
        radius   = 6'd4;
        fill     = 1'b0;
        colour   = 3'd6;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        check_trace("held_start_second", 1'b0);
    endtask

    task automatic test_reset_mid();
        accept(80, 60, 59, 1'b0, 7, 1'b0);
        repeat (40) @(posedge CLOCK_50);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_plot !== 1'b0 || vga_colour !== 3'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid async: got x=%0d y=%0d plot=%b col=%0d busy=%b done=%b want all 0",
                     vga_x, vga_y, vga_plot, vga_colour, busy, done);
        end
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            #1;
            checks++;
            if (vga_plot !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid abandoned cycle %0d: got plot=%b busy=%b want 0 0",
                         i, vga_plot, busy);
            end
        end
        accept(60, 40, 6, 1'b1, 3, 1'b0);
        check_trace("after_reset", 1'b0);
    endtask

    task automatic test_random();
        int cx, cy, r, col;
        bit f;
        for (int n = 0; n < 12; n++) begin
            cx  = $urandom_range(0, 200);
            cy  = $urandom_range(0, 127);
            r   = $urandom_range(0, 15);
            f   = 1'($urandom_range(0, 1));
            col = $urandom_range(0, 7);
            accept(cx, cy, r, f, col, 1'b0);
            check_trace($sformatf("random%0d", n), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_outline_r1();
        test_outline_r5();
        test_fill();
        test_clip();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circle_engine.md
Name: circle_engine

Overview:
- Parametrised Bresenham circle rasteriser for the VGA adapter path; successor to the fixed 160x120 outline-only circle drawer.
- Accepts centre, radius, colour and mode on a start handshake. Emits one pixel per clock on the vga_x/vga_y/vga_plot/vga_colour bus.
- Adds filled-disc mode, screen clipping and a busy/done handshake.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- R_W, 6, width of radius
- COL_W, 3, colour width
- X_MAX, 159, largest visible x
- Y_MAX, 119, largest visible y

Ports:
- CLOCK_50  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- fill  in  1  0 = outline, 1 = filled disc; latched on accept
- centre_x  in  X_W  centre x; latched on accept
- centre_y  in  Y_W  centre y; latched on accept
- radius  in  R_W  radius; latched on accept
- colour  in  COL_W  colour; latched on accept
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_plot  out  1  pixel write strobe
- vga_colour  out  COL_W  pixel colour
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, any state): state=IDLE; vga_x=0, vga_y=0, vga_plot=0, vga_colour=0, busy=0, done=0. An in-flight circle is abandoned and no further pixels are emitted.
- States: IDLE, INIT, PLOT (outline), SPAN (fill), STEP, DONE.
- IDLE:
  - start=1 at a clock edge accepts the request, latches all inputs, sets busy=1 and moves to INIT.
  - start while busy is ignored; it is not queued.
- INIT (1 cycle):
  - x=0, y=radius, d=3-2*radius.
  - d is signed, R_W+4 bits; cx/cy and generated coordinates are signed, width+2 bits.
  - Next state is PLOT if fill=0, else SPAN.
- Outputs are registered. The first pixel's vga_plot is high on the 2nd rising edge after the accept edge.
- PLOT, one point per cycle in fixed order:
  - k=0..7: (cx+x,cy+y), (cx+y,cy+x), (cx-x,cy+y), (cx-y,cy+x), (cx-x,cy-y), (cx-y,cy-x), (cx+x,cy-y), (cx+y,cy-x).
  - Duplicate points are not suppressed.
  - After k=7, go to STEP.
- SPAN, per step, four horizontal spans in order, each left to right, one pixel per cycle, endpoints inclusive:
  - row cy+y, x from cx-x to cx+x
  - row cy-y, x from cx-x to cx+x
  - row cy+x, x from cx-y to cx+y
  - row cy-x, x from cx-y to cx+y
  - After the 4th span, go to STEP.
- STEP (1 cycle, vga_plot=0):
  - If d<0: d=d+4x+6.
  - Else: d=d+4(x-y)+10, y=y-1.
  - Then x=x+1.
  - If the new x<=y, return to PLOT/SPAN; else go to DONE.
- DONE (1 cycle): done=1, busy drops to 0 in the same cycle, then IDLE.
  - start is sampled again from the following edge.
  - A start in the DONE cycle is ignored.
- Clipping: a generated pixel with x<0, x>X_MAX, y<0 or y>Y_MAX still consumes its cycle, but vga_plot=0.
  - vga_x/vga_y on those cycles are don't-care.
  - Clipping never changes the sequence or the cycle count.
- vga_colour equals the latched colour whenever vga_plot=1.
- vga_plot=0 in IDLE, INIT, STEP and DONE.
- radius=0 is legal: exactly one iteration with x=y=0.

Test Plan:
- Outline, centre (80,60), r=1 -> exactly 8 vga_plot pulses, in order: (80,61), (81,60), (80,61), (79,60), (80,59), (79,60), (80,59), (81,60). Then done pulses once and busy falls.
- Outline, centre (80,60), r=5 -> 4 iterations (x=0..3), 32 plot cycles. Every plotted point satisfies |dx|,|dy|<=5, and (85,60) is the second pixel.
- Fill, centre (10,10), r=0 -> 4 plots, all (10,10). Filled r=2 at (20,20) -> every pixel with dx²+dy²<=4 is written at least once, with no pixel outside radius 2.
- Clipping, outline, centre (0,0), r=5 -> same cycle count as the r=5 case (32 plot cycles). vga_plot is high only for points with x>=0 and y>=0; none of those strobes carry a negative-wrapped coordinate.
- Handshake: start re-pulsed while busy with different centre -> ignored, the original circle completes unchanged. Start held high across DONE -> a new circle begins on the first IDLE edge.
- Reset asserted mid-PLOT (r=59 at (80,60)) -> all outputs 0 asynchronously, no further vga_plot. After release, a new start draws correctly.
